// File: rtl/spi_bus_bridge.sv
// SPI command decoder driving a single-outstanding byte bus.
// Commands carry address, optional burst length and write data.
module spi_bus_bridge #(
    parameter int ADDR_WIDTH = 17,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  cs_n,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic [7:0]            tx_byte,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]            bus_wdata,
    input  logic [7:0]            bus_rdata,
    output logic                  bus_rw_b,
    output logic                  bus_req,
    input  logic                  bus_done,
    output logic                  xfer_done,
    output logic                  overrun,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        S_CMD, S_ADDR_HI, S_ADDR_LO, S_LEN,
        S_WDATA, S_BUS, S_RWAIT, S_DRAIN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;

    state_t                 st;
    logic                   burst;
    logic                   wr;
    logic                   aborting;
    logic [LEN_WIDTH-1:0]   remaining;
    logic [ADDR_WIDTH-1:0]  cmd_addr;

    assign state = st;

    // Upper address bits ride in the command byte when the bus is wider than 16.
    generate
        if (ADDR_WIDTH > 16) begin : g_hi
            assign cmd_addr = {rx_byte[ADDR_WIDTH-17:0], bus_addr[15:0]};
        end else begin : g_nohi
            assign cmd_addr = bus_addr;
        end
    endgenerate

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            st        <= S_CMD;
            bus_req   <= 1'b0;
            bus_rw_b  <= 1'b1;
            xfer_done <= 1'b0;
            overrun   <= 1'b0;
            tx_byte   <= 8'h00;
            bus_addr  <= '0;
            bus_wdata <= 8'h00;
            remaining <= '0;
            burst     <= 1'b0;
            wr        <= 1'b0;
            aborting  <= 1'b0;
        end else begin
            xfer_done <= 1'b0;
            if (st == S_BUS) begin
                if (rx_valid && !cs_n)
                    overrun <= 1'b1;
                if (cs_n)
                    aborting <= 1'b1;
                if (bus_done) begin
                    bus_req  <= 1'b0;
                    aborting <= 1'b0;
                    if (!wr)
                        tx_byte <= bus_rdata;
                    if (aborting || cs_n) begin
                        st        <= S_CMD;
                        xfer_done <= 1'b1;
                    end else if (remaining == '0) begin
                        st        <= wr ? S_CMD : S_DRAIN;
                        xfer_done <= wr;
                    end else begin
                        remaining <= remaining - LEN_ONE;
                        bus_addr  <= bus_addr + ADDR_ONE;
                        st        <= wr ? S_WDATA : S_RWAIT;
                    end
                end
            end else if (cs_n) begin
                // A frame closing outside a bus cycle ends the command.
                xfer_done <= (st != S_CMD);
                st        <= S_CMD;
            end else if (rx_valid) begin
                unique case (st)
                    S_CMD: begin
                        burst     <= rx_byte[7];
                        wr        <= rx_byte[6];
                        bus_rw_b  <= ~rx_byte[6];
                        remaining <= '0;
                        if (rx_byte[5]) begin
                            bus_addr <= bus_addr + ADDR_ONE;
                            bus_req  <= !rx_byte[7] && !rx_byte[6];
                            st <= rx_byte[7] ? S_LEN :
                                  rx_byte[6] ? S_WDATA : S_BUS;
                        end else begin
                            bus_addr <= cmd_addr;
                            st       <= S_ADDR_HI;
                        end
                    end
                    S_ADDR_HI: begin
                        bus_addr[15:8] <= rx_byte;
                        st             <= S_ADDR_LO;
                    end
                    S_ADDR_LO: begin
                        bus_addr[7:0] <= rx_byte;
                        bus_req       <= !burst && !wr;
                        st <= burst ? S_LEN : wr ? S_WDATA : S_BUS;
                    end
                    S_LEN: begin
                        remaining <= rx_byte[LEN_WIDTH-1:0];
                        bus_req   <= !wr;
                        st        <= wr ? S_WDATA : S_BUS;
                    end
                    S_WDATA: begin
                        bus_wdata <= rx_byte;
                        bus_rw_b  <= 1'b0;
                        bus_req   <= 1'b1;
                        st        <= S_BUS;
                    end
                    S_RWAIT: begin
                        bus_req <= 1'b1;
                        st      <= S_BUS;
                    end
                    S_DRAIN: begin
                        xfer_done <= 1'b1;
                        st        <= S_CMD;
                    end
                    S_BUS: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Randomised bench for spi_bus_bridge against a transaction-level model.
// Bus responder plays the arbiter; one compare process checks every cycle.
module tb_spi_bus_bridge;
    localparam int AW = 17;

    logic          sys_clk = 1'b0;
    logic          reset, cs_n, rx_valid, bus_done;
    logic          bus_rw_b, bus_req, xfer_done, overrun;
    logic [7:0]    rx_byte, tx_byte, bus_wdata, bus_rdata;
    logic [AW-1:0] bus_addr;
    logic [2:0]    state;

    always #5 sys_clk = ~sys_clk;

    spi_bus_bridge #(.ADDR_WIDTH(AW), .LEN_WIDTH(8)) dut (
        .sys_clk(sys_clk), .reset(reset), .cs_n(cs_n),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .tx_byte(tx_byte),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_rw_b(bus_rw_b), .bus_req(bus_req),
        .bus_done(bus_done), .xfer_done(xfer_done), .overrun(overrun),
        .state(state)
    );

    typedef struct {
        logic [AW-1:0] a;
        bit            wr;
        logic [7:0]    d;
    } req_t;

    req_t          exp_q[$];
    int            rq_idx = 0;
    logic [AW-1:0] m_addr = '0;
    logic [7:0]    m_tx = 8'h00;
    bit            m_ovr = 1'b0;
    bit            m_req = 1'b0;
    int            exp_xfer = 0;
    int            xfer_cnt = 0;
    int            force_delay = -1;
    logic [7:0]    rd_force[$];
    logic [7:0]    wd_force[$];
    logic [AW-1:0] seen_addr[$];
    logic [7:0]    seen_tx[$];
    logic [7:0]    seen_wd[$];
    int            checks = 0;
    int            passes = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h want %0h", name, act, req);
    endtask

    // Per-cycle comparison against the model
    always @(posedge sys_clk) begin
        #1;
        if (xfer_done === 1'b1) xfer_cnt++;
        chk("bus_req", {31'd0, bus_req}, {31'd0, m_req});
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        chk("tx_byte", {24'd0, tx_byte}, {24'd0, m_tx});
        if (bus_req === 1'b1) begin
            if (rq_idx < exp_q.size()) begin
                chk("bus_addr", bus_addr, exp_q[rq_idx].a);
                chk("bus_rw_b", {31'd0, bus_rw_b}, {31'd0, !exp_q[rq_idx].wr});
                if (exp_q[rq_idx].wr)
                    chk("bus_wdata", {24'd0, bus_wdata}, {24'd0, exp_q[rq_idx].d});
            end else begin
                checks++;
                $display("FAIL extra_req: got request at %0h, none expected", bus_addr);
            end
        end
    end

    // Arbiter: one completion per observed request
    initial begin
        int d;
        bus_done  = 1'b0;
        bus_rdata = 8'h00;
        forever begin
            @(negedge sys_clk);
            if (bus_req === 1'b1) begin
                d = force_delay >= 0 ? force_delay : int'($urandom_range(0, 3));
                repeat (d) @(negedge sys_clk);
                bus_rdata = rd_force.size() > 0 ? rd_force.pop_front() : 8'($urandom);
                bus_done  = 1'b1;
                if (bus_req === 1'b1 && rq_idx < exp_q.size()) begin
                    if (!exp_q[rq_idx].wr) begin
                        m_tx = bus_rdata;
                        seen_tx.push_back(bus_rdata);
                    end
                    seen_addr.push_back(bus_addr);
                    seen_wd.push_back(bus_wdata);
                    rq_idx++;
                    m_req = 1'b0;
                end
                @(negedge sys_clk);
                bus_done = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus_req === 1'b1 && n < 60) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 60) begin
            checks++;
            $display("FAIL bus_timeout: bus_req still %0b after %0d cycles, need 0", bus_req, n);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit trig);
        @(negedge sys_clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        if (trig) m_req = 1'b1;
        @(negedge sys_clk);
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
        wait_idle();
        repeat ($urandom_range(0, 2)) @(negedge sys_clk);
    endtask

    task automatic do_cmd(input bit burst, input bit wr, input bit inc,
                          input logic [AW-1:0] a, input int len,
                          input bit trunc, input bit rnd);
        int            n;
        int            base;
        logic [AW-1:0] s;
        logic [7:0]    c;
        logic [7:0]    d;
        n = burst ? len + 1 : 1;
        s = inc ? AW'(m_addr + 1) : a;
        c = rnd ? 8'($urandom) : 8'h00;
        c[7] = burst;
        c[6] = wr;
        c[5] = inc;
        if (!inc) c[0] = a[16];
        @(negedge sys_clk);
        cs_n = 1'b0;
        if (trunc) begin
            send(c, 1'b0);
            send(a[15:8], 1'b0);
            send(a[7:0], 1'b0);
            m_addr = a;
            exp_xfer++;
        end else begin
            base = exp_q.size();
            for (int i = 0; i < n; i++) begin
                d = wd_force.size() > 0 ? wd_force.pop_front() : 8'($urandom);
                exp_q.push_back('{a: AW'(s + AW'(i)), wr: wr, d: d});
            end
            m_addr = AW'(s + AW'(n - 1));
            send(c, inc && !burst && !wr);
            if (!inc) begin
                send(a[15:8], 1'b0);
                send(a[7:0], !burst && !wr);
            end
            if (burst) send(8'(len), !wr);
            for (int i = 0; i < n; i++) begin
                if (wr) send(exp_q[base + i].d, 1'b1);
                else    send(8'($urandom), i < n - 1);
            end
            exp_xfer++;
        end
        @(negedge sys_clk);
        cs_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        chk("xfer_cnt", xfer_cnt, exp_xfer);
        chk("req_cnt", rq_idx, exp_q.size());
    endtask

    // Single write whose bus cycle is interrupted by the bench
    task automatic start_single_write(input logic [AW-1:0] a, input int dly);
        logic [7:0] d;
        d = 8'($urandom);
        force_delay = dly;
        exp_q.push_back('{a: a, wr: 1'b1, d: d});
        m_addr = a;
        @(negedge sys_clk);
        cs_n = 1'b0;
        send({7'b0100000, a[16]}, 1'b0);
        send(a[15:8], 1'b0);
        send(a[7:0], 1'b0);
        @(negedge sys_clk);
        rx_byte  = d;
        rx_valid = 1'b1;
        m_req    = 1'b1;
        @(negedge sys_clk);
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tx"}, {24'd0, tx_byte}, 32'h00);
        chk({tag, "_addr"}, bus_addr, 32'h0);
        chk({tag, "_wdata"}, {24'd0, bus_wdata}, 32'h00);
        chk({tag, "_rw_b"}, {31'd0, bus_rw_b}, 32'h1);
        chk({tag, "_req"}, {31'd0, bus_req}, 32'h0);
        chk({tag, "_xfer"}, {31'd0, xfer_done}, 32'h0);
        chk({tag, "_ovr"}, {31'd0, overrun}, 32'h0);
    endtask

    initial begin
        logic [AW-1:0] a;
        bit b, w, inc, tr;
        reset    = 1'b1;
        cs_n     = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (3) @(negedge sys_clk);
        check_reset_values("reset");
        reset = 1'b0;

        // Single write 0x41,0x12,0x34,0xAB
        wd_force.push_back(8'hAB);
        do_cmd(1'b0, 1'b1, 1'b0, 17'h11234, 0, 1'b0, 1'b0);
        chk("w1_addr", seen_addr[$], 32'h11234);
        chk("w1_data", {24'd0, seen_wd[$]}, 32'hAB);

        // Write burst wrapping the top of the address space
        wd_force = '{8'h01, 8'h02, 8'h03};
        do_cmd(1'b1, 1'b1, 1'b0, 17'h1FFFE, 2, 1'b0, 1'b0);
        chk("wb_addr0", seen_addr[$-2], 32'h1FFFE);
        chk("wb_addr1", seen_addr[$-1], 32'h1FFFF);
        chk("wb_addr2", seen_addr[$], 32'h00000);
        chk("wb_data2", {24'd0, seen_wd[$]}, 32'h03);

        // Read burst 0x80,0x80,0x00,0x01
        rd_force = '{8'h5A, 8'hA5};
        do_cmd(1'b1, 1'b0, 1'b0, 17'h08000, 1, 1'b0, 1'b0);
        chk("rb_addr0", seen_addr[$-1], 32'h08000);
        chk("rb_addr1", seen_addr[$], 32'h08001);
        chk("rb_tx0", {24'd0, seen_tx[$-1]}, 32'h5A);
        chk("rb_tx1", {24'd0, tx_byte}, 32'hA5);

        // INC read 0x20
        do_cmd(1'b0, 1'b0, 1'b1, '0, 0, 1'b0, 1'b0);
        chk("inc_addr", seen_addr[$], 32'h08002);

        for (int k = 0; k < 40; k++) begin
            b   = 1'($urandom);
            w   = 1'($urandom);
            inc = 1'($urandom);
            a   = (k % 8 == 0) ? 17'h1FFFD : AW'($urandom);
            tr  = !inc && (b || w) && ($urandom_range(0, 4) == 0);
            do_cmd(b, w, inc, a, int'($urandom_range(0, 4)), tr, 1'b1);
        end

        // Frame closes mid bus cycle of a 4-byte write burst
        a = AW'($urandom);
        force_delay = 5;
        exp_q.push_back('{a: a, wr: 1'b1, d: 8'h5C});
        m_addr = a;
        @(negedge sys_clk);
        cs_n = 1'b0;
        send({7'b1100000, a[16]}, 1'b0);
        send(a[15:8], 1'b0);
        send(a[7:0], 1'b0);
        send(8'd3, 1'b0);
        @(negedge sys_clk);
        rx_byte  = 8'h5C;
        rx_valid = 1'b1;
        m_req    = 1'b1;
        @(negedge sys_clk);
        rx_valid = 1'b0;
        cs_n     = 1'b1;
        exp_xfer++;
        wait_idle();
        repeat (8) @(negedge sys_clk);
        force_delay = -1;
        chk("abort_xfer", xfer_cnt, exp_xfer);
        chk("abort_reqs", rq_idx, exp_q.size());

        // Byte arriving during a bus cycle
        start_single_write(AW'($urandom), 4);
        rx_byte  = 8'hEE;
        rx_valid = 1'b1;
        m_ovr    = 1'b1;
        @(negedge sys_clk);
        rx_valid = 1'b0;
        wait_idle();
        force_delay = -1;
        @(negedge sys_clk);
        cs_n = 1'b1;
        exp_xfer++;
        repeat (2) @(negedge sys_clk);
        chk("ovr_xfer", xfer_cnt, exp_xfer);
        chk("ovr_flag", {31'd0, overrun}, 32'h1);
        do_cmd(1'b1, 1'b0, 1'b0, AW'($urandom), 2, 1'b0, 1'b1);

        // Reset during a bus cycle; the late completion must be ignored
        start_single_write(AW'($urandom), 6);
        reset = 1'b1;
        m_req = 1'b0;
        m_ovr = 1'b0;
        m_tx  = 8'h00;
        m_addr = '0;
        exp_q.delete();
        rq_idx = 0;
        @(negedge sys_clk);
        reset = 1'b0;
        cs_n  = 1'b1;
        check_reset_values("midbus_rst");
        repeat (12) @(negedge sys_clk);
        force_delay = -1;
        chk("rst_xfer", xfer_cnt, exp_xfer);
        chk("rst_reqs", rq_idx, 0);

        do_cmd(1'b0, 1'b0, 1'b1, '0, 0, 1'b0, 1'b1);
        chk("post_rst_inc", seen_addr[$], 32'h00001);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exhausted");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1);
    end

endmodule
